// File: rtl/mt_fetch_sched.sv
// Barrel-processor fetch scheduler: round-robin thread pick and per-thread PC file.
// Redirects to the thread being picked in the same cycle bypass into imem_addr.
module mt_fetch_sched #(
  parameter int                    NUM_THREADS  = 8,
  parameter int                    BITS_THREADS = $clog2(NUM_THREADS),
  parameter int                    ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC     = '0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    stall_i,
  input  logic [NUM_THREADS-1:0]  thread_en_i,
  input  logic                    redirect_valid_i,
  input  logic [BITS_THREADS-1:0] redirect_tid_i,
  input  logic [ADDR_WIDTH-1:0]   redirect_pc_i,
  output logic                    imem_en_o,
  output logic [ADDR_WIDTH-1:0]   imem_addr_o,
  output logic                    fetch_valid_o,
  output logic [BITS_THREADS-1:0] fetch_tid_o,
  output logic [ADDR_WIDTH-1:0]   fetch_pc_o
);

  logic [ADDR_WIDTH-1:0]   pc_q [NUM_THREADS];
  logic [ADDR_WIDTH-1:0]   pc_d [NUM_THREADS];
  logic [BITS_THREADS-1:0] last_tid_q, last_tid_d;
  logic                    fetch_valid_q, fetch_valid_d;
  logic [BITS_THREADS-1:0] fetch_tid_q, fetch_tid_d;
  logic [ADDR_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;

  logic [BITS_THREADS-1:0] sel;
  logic [BITS_THREADS-1:0] cand;
  logic                    found;
  logic                    any_en;
  logic                    issue;
  logic [ADDR_WIDTH-1:0]   redir_pc;
  logic [ADDR_WIDTH-1:0]   eff_pc;
  logic [1:0]              unused_redir_lsbs;

  assign unused_redir_lsbs = redirect_pc_i[1:0];
  assign redir_pc = {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
  assign any_en   = |thread_en_i;
  assign issue    = !stall_i && any_en;

  // Scan last+1 .. last+NUM_THREADS; the final candidate wraps back to last_tid itself.
  always_comb begin
    sel   = '0;
    cand  = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_THREADS; i++) begin
      cand = last_tid_q + BITS_THREADS'(i);
      if (!found && thread_en_i[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    eff_pc = pc_q[sel];
    if (redirect_valid_i && (redirect_tid_i == sel)) begin
      eff_pc = redir_pc;
    end
  end

  always_comb begin
    pc_d          = pc_q;
    last_tid_d    = last_tid_q;
    fetch_valid_d = fetch_valid_q;
    fetch_tid_d   = fetch_tid_q;
    fetch_pc_d    = fetch_pc_q;
    if (redirect_valid_i) begin
      pc_d[redirect_tid_i] = redir_pc;
    end
    if (issue) begin
      pc_d[sel]     = eff_pc + ADDR_WIDTH'(4);
      last_tid_d    = sel;
      fetch_valid_d = 1'b1;
      fetch_tid_d   = sel;
      fetch_pc_d    = eff_pc;
    end else if (!stall_i) begin
      fetch_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        pc_q[t] <= RESET_PC;
      end
      last_tid_q    <= BITS_THREADS'(NUM_THREADS - 1);
      fetch_valid_q <= 1'b0;
      fetch_tid_q   <= '0;
      fetch_pc_q    <= '0;
    end else begin
      pc_q          <= pc_d;
      last_tid_q    <= last_tid_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_tid_q   <= fetch_tid_d;
      fetch_pc_q    <= fetch_pc_d;
    end
  end

  assign imem_en_o     = issue;
  assign imem_addr_o   = eff_pc;
  assign fetch_valid_o = fetch_valid_q;
  assign fetch_tid_o   = fetch_tid_q;
  assign fetch_pc_o    = fetch_pc_q;

endmodule
